done_cycle_multi: RTL



---
 rtl/done_cycle_pkg.sv | 9 +
 rtl/done_cycle_channel.sv | 92 +++++++++
 rtl/done_cycle_multi.sv | 41 ++++
 3 files changed

// File: rtl/done_cycle_pkg.sv
// done_cycle_pkg: shared definitions for the multi-channel
// cycle-count completion unit.
package done_cycle_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] COUNT = 2'd1;
  localparam logic [1:0] FIN   = 2'd2;

endpackage

// File: rtl/done_cycle_channel.sv
// done_cycle_channel: one channel counting running cycles
// against a latched amount, repeated for a latched iteration count.
module done_cycle_channel
  import done_cycle_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ITER_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              running,
  input  logic              enable,
  input  logic [DATA_W-1:0] amount,
  input  logic [ITER_W-1:0] iter,
  output logic              ch_done,
  output logic              tick
);

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic [DATA_W-1:0] cnt;
  logic [DATA_W-1:0] amt_q;
  logic [ITER_W-1:0] it;
  logic [ITER_W-1:0] iter_q;
  logic [ITER_W-1:0] it_last;
  logic              adv;
  logic              cnt_end;
  logic              it_end;

  // run wins over running, so a restart never advances the old count
  assign adv     = (state == COUNT) && running && !run;
  assign cnt_end = (cnt == amt_q);
  assign it_last = iter_q - 1'b1;
  assign it_end  = (it == it_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      run: begin
        if (enable && (iter != '0)) begin
          state_nx = COUNT;
        end else begin
          state_nx = FIN;
        end
      end
      (adv && cnt_end && it_end): state_nx = FIN;
      default: ;
    endcase
  end

  always_comb begin
    ch_done = (state == IDLE) || (state == FIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      it     <= '0;
      amt_q  <= '0;
      iter_q <= '0;
      tick   <= 1'b0;
    end else if (run) begin
      cnt    <= '0;
      it     <= '0;
      amt_q  <= amount;
      iter_q <= iter;
      tick   <= 1'b0;
    end else begin
      tick <= adv && cnt_end;
      if (adv) begin
        if (cnt_end) begin
          cnt <= '0;
          if (!it_end) begin
            it <= it + 1'b1;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/done_cycle_multi.sv
// done_cycle_multi: N_CH independent cycle-count channels with
// an aggregated all-complete flag.
module done_cycle_multi
  import done_cycle_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ITER_W = 8,
  parameter int N_CH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic                   running,
  output logic                   done,
  input  logic [N_CH*DATA_W-1:0] amount,
  input  logic [N_CH*ITER_W-1:0] iter,
  input  logic [N_CH-1:0]        enable,
  output logic [N_CH-1:0]        ch_done,
  output logic [N_CH-1:0]        tick
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    done_cycle_channel #(
      .DATA_W(DATA_W),
      .ITER_W(ITER_W)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .run    (run),
      .running(running),
      .enable (enable[g]),
      .amount (amount[g*DATA_W +: DATA_W]),
      .iter   (iter[g*ITER_W +: ITER_W]),
      .ch_done(ch_done[g]),
      .tick   (tick[g])
    );
  end

  assign done = &ch_done;

endmodule
